core_result_buffer: RTL

//  Downstream stage of CORE. Captures each one-cycle result pulse from CORE
//  (out_valid/out_data plus the in_mode that produced it) into a small FIFO.

---
 rtl/core_result_buffer.sv | 106 ++++++++++
 1 files changed

// File: rtl/core_result_buffer.sv
// Purpose : in-order result FIFO behind CORE; captures {mode,data} strobes, counts accepted results, flags drops.
// Latency : 1 cycle push-to-out_valid (no fall-through); up to 1 result in and 1 out per cycle.
// Backpressure: out_ready=0 stalls the head entry; pushes into a full FIFO without a same-cycle pop are dropped and set overflow.
//
// Ports:
//   clk, rst_n (sync, active-low), clr (sync soft clear)
//   in_valid/in_mode/in_data   : result strobe from CORE (never stalled)
//   out_valid/out_ready        : valid/ready handshake toward consumer
//   out_mode/out_data          : head entry, driven from registers only
//   count                      : entries held, 0..DEPTH
//   overflow                   : sticky drop indicator
//   total                      : accepted results since reset/clr, wraps
module core_result_buffer #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4,
    parameter int TOT_W  = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              out_mode,
    output logic [DATA_W-1:0] out_data,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic [TOT_W-1:0]  total
);

    typedef struct packed {
        logic              mode;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count_q;
    logic               overflow_q;
    logic [TOT_W-1:0]   total_q;

    logic push;
    logic pop;
    logic full;
    logic accept;
    logic drop;

    assign push   = in_valid;
    assign pop    = out_valid & out_ready;
    assign full   = (count_q == FULL_CNT);
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            total_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            // Storage is left stale; count=0 hides it from the output.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            total_q    <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= '{mode: in_mode, data: in_data};
                wr_ptr      <= wr_ptr + 1'b1;
                total_q     <= total_q + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head is read straight from storage; nothing from in_* reaches here combinationally.
    assign out_valid = (count_q != '0);
    assign out_mode  = mem[rd_ptr].mode;
    assign out_data  = mem[rd_ptr].data;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign total     = total_q;

endmodule
